// File: rtl/ex_div_if.sv
// Request/result bundle between the EX stage and the iterative divider.
// EX drives operands and start/annul; the divider returns result, ready and busy.
interface ex_div_if #(
  parameter int WIDTH = 32
);
  logic                 signed_div;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 start;
  logic                 annul;
  logic [2*WIDTH-1:0]   result;
  logic                 ready;
  logic                 busy;

  modport master (
    output signed_div, opdata1, opdata2, start, annul,
    input  result, ready, busy
  );

  modport slave (
    input  signed_div, opdata1, opdata2, start, annul,
    output result, ready, busy
  );
endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider; start sampled at edge T gives ready at T+WIDTH+2 (T+2 for a zero divisor).
// EX holds start until ready; busy stalls the pipeline, annul abandons the op without asserting ready.
module ex_div #(
  parameter int WIDTH = 32
) (
  input  logic    clk,
  input  logic    rst,
  ex_div_if.slave div_if
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   dvs_q;
  logic               neg_quo_q;
  logic               neg_rem_q;
  logic [2*WIDTH-1:0] result_q;
  logic               ready_q;
  logic               busy_q;

  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH-1:0]   quo_d;
  logic [WIDTH-1:0]   rem_d;
  logic [WIDTH:0]     rem_sh;
  logic [WIDTH:0]     trial;

  always_comb begin
    // Negating the most negative value yields itself, which reads correctly as unsigned magnitude.
    a_abs  = (div_if.signed_div && div_if.opdata1[WIDTH-1]) ? -div_if.opdata1 : div_if.opdata1;
    b_abs  = (div_if.signed_div && div_if.opdata2[WIDTH-1]) ? -div_if.opdata2 : div_if.opdata2;
    rem_sh = {rem_q, quo_q[WIDTH-1]};
    trial  = rem_sh - {1'b0, dvs_q};
    rem_d  = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_d  = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          busy_q  <= 1'b0;
          if (div_if.start && !div_if.annul) begin
            if (div_if.opdata2 == '0) begin
              state_q <= S_BYZERO;
            end else begin
              quo_q     <= a_abs;
              rem_q     <= '0;
              dvs_q     <= b_abs;
              neg_quo_q <= div_if.signed_div & (div_if.opdata1[WIDTH-1] ^ div_if.opdata2[WIDTH-1]);
              neg_rem_q <= div_if.signed_div & div_if.opdata1[WIDTH-1];
              cnt_q     <= '0;
              state_q   <= S_ON;
            end
          end
        end
        S_BYZERO: begin
          busy_q <= !div_if.annul;
          if (div_if.annul) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= '0;
            state_q  <= S_END;
          end
        end
        S_ON: begin
          busy_q <= !div_if.annul;
          if (div_if.annul) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CW'(WIDTH)) begin
            result_q <= {neg_rem_q ? -rem_q : rem_q, neg_quo_q ? -quo_q : quo_q};
            state_q  <= S_END;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_END: begin
          busy_q <= 1'b0;
          if (div_if.annul || !div_if.start) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end else begin
            ready_q <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign div_if.result = result_q;
  assign div_if.ready  = ready_q;
  assign div_if.busy   = busy_q;
endmodule

// File: tb/tb_ex_div.sv
// Randomized scoreboard bench for ex_div: driver queues expected {HI,LO} and ready cycle,
// a monitor pops on each rising ready and compares value and latency.
module tb_ex_div;
  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  bit   rdy_prev;

  logic [63:0] sb_res[$];
  int          sb_cyc[$];

  ex_div_if #(.WIDTH(32)) dif ();

  ex_div #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .div_if (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] model(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 32'h0) return 64'h0;
    if (sgn) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Full op: issue, scramble operands mid-op, wait for ready, hold one cycle, release.
  task automatic run_op(input bit sgn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int busy_n, waited;
    exp = model(sgn, a, b);
    @(negedge clk);
    dif.signed_div = sgn;
    dif.opdata1    = a;
    dif.opdata2    = b;
    dif.start      = 1'b1;
    sb_res.push_back(exp);
    sb_cyc.push_back(cyc + ((b == 32'h0) ? 3 : 35));
    busy_n = 0;
    waited = 0;
    @(negedge clk);
    dif.opdata1    = $urandom;
    dif.opdata2    = $urandom;
    dif.signed_div = 1'($urandom_range(0, 1));
    while (!dif.ready && waited < 100) begin
      if (dif.busy) busy_n++;
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) begin
      check("ready_timeout", 64'(waited), 64'(0));
      dif.start = 1'b0;
      return;
    end
    check("busy_cycles", 64'(busy_n), (b == 32'h0) ? 64'd1 : 64'd33);
    @(negedge clk);
    check("hold_ready", {63'h0, dif.ready}, 64'h1);
    check("hold_result", dif.result, exp);
    dif.start = 1'b0;
    @(negedge clk);
    check("drop_ready", {63'h0, dif.ready}, 64'h0);
  endtask

  // Monitor: each rising ready must match the oldest outstanding expectation.
  initial begin
    rdy_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rdy_prev = 1'b0;
      end else begin
        if (dif.ready && !rdy_prev) begin
          if (sb_res.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_ready: got result %h with no op outstanding", dif.result);
          end else begin
            check("result", dif.result, sb_res.pop_front());
            check("latency", 64'(cyc), 64'(sb_cyc.pop_front()));
          end
        end
        rdy_prev = dif.ready;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    logic [31:0] a, b;
    cyc            = 0;
    vectors        = 0;
    miscompares    = 0;
    rst            = 1'b1;
    dif.signed_div = 1'b0;
    dif.opdata1    = '0;
    dif.opdata2    = '0;
    dif.start      = 1'b0;
    dif.annul      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", {63'h0, dif.ready}, 64'h0);
    check("rst_busy", {63'h0, dif.busy}, 64'h0);
    check("rst_result", dif.result, 64'h0);
    rst = 1'b0;

    run_op(1'b0, 32'd7, 32'd2);
    check("divu_7_2", dif.result, {32'h1, 32'h3});
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2);
    run_op(1'b1, 32'd7, 32'hFFFF_FFFE);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_overflow", dif.result, {32'h0, 32'h8000_0000});
    run_op(1'b0, 32'd1234, 32'd0);

    // Annul at cnt=10, then verify ready never rises.
    @(negedge clk);
    dif.signed_div = 1'b0;
    dif.opdata1    = 32'd1000;
    dif.opdata2    = 32'd3;
    dif.start      = 1'b1;
    repeat (11) @(negedge clk);
    check("busy_mid_op", {63'h0, dif.busy}, 64'h1);
    dif.annul = 1'b1;
    @(negedge clk);
    check("annul_busy", {63'h0, dif.busy}, 64'h0);
    dif.start = 1'b0;
    dif.annul = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (dif.ready) seen = 1'b1;
    end
    check("annul_no_ready", {63'h0, seen}, 64'h0);
    run_op(1'b0, 32'd100, 32'd7);
    check("after_annul", dif.result, {32'd2, 32'd14});

    // Annul while in BYZERO.
    @(negedge clk);
    dif.opdata2 = 32'h0;
    dif.start   = 1'b1;
    @(negedge clk);
    dif.annul = 1'b1;
    @(negedge clk);
    check("annul_byzero_busy", {63'h0, dif.busy}, 64'h0);
    dif.start = 1'b0;
    dif.annul = 1'b0;
    repeat (5) @(negedge clk);
    check("annul_byzero_result", dif.result, {32'd2, 32'd14});

    // Reset pulse mid-op.
    @(negedge clk);
    dif.opdata1 = 32'hDEAD_BEEF;
    dif.opdata2 = 32'd3;
    dif.start   = 1'b1;
    repeat (15) @(negedge clk);
    rst       = 1'b1;
    dif.start = 1'b0;
    @(negedge clk);
    check("midrst_busy", {63'h0, dif.busy}, 64'h0);
    check("midrst_ready", {63'h0, dif.ready}, 64'h0);
    check("midrst_result", dif.result, 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 7))
        0:       b = 32'h0;
        1:       b = 32'h1;
        2:       b = 32'hFFFF_FFFF;
        3:       b = 32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      a = ($urandom_range(0, 5) == 0) ? 32'h8000_0000 : $urandom;
      run_op(1'($urandom_range(0, 1)), a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 64'(sb_res.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
